// File: rtl/snic_rv_pkg.sv
// Shared definitions for the DMEM AXI-Lite slave: response codes, arbitration
// priority encoding and controller state encoding.
package snic_rv_pkg;

   localparam int unsigned RESP_W = 2;

   localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
   localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {
      PRIO_WRITE = 1'b0,
      PRIO_READ  = 1'b1
   } prio_e;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_EXEC = 3'd1,
      WR_RESP = 3'd2,
      RD_EXEC = 3'd3,
      RD_RESP = 3'd4
   } state_e;

endpackage

// File: rtl/taxi_axil_if.sv
// AXI-Lite bundle with separate write-side and read-side slave views.
interface taxi_axil_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned STRB_W = DATA_W/8
);
   logic [ADDR_W-1:0] awaddr;
   logic [2:0]        awprot;
   logic              awvalid;
   logic              awready;
   logic [DATA_W-1:0] wdata;
   logic [STRB_W-1:0] wstrb;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;
   logic [ADDR_W-1:0] araddr;
   logic [2:0]        arprot;
   logic              arvalid;
   logic              arready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;

   modport wr_slv (
      input  awaddr, awprot, awvalid,
      output awready,
      input  wdata, wstrb, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready
   );

   modport rd_slv (
      input  araddr, arprot, arvalid,
      output arready,
      output rdata, rresp, rvalid,
      input  rready
   );
endinterface

// File: rtl/snic_sp_ram.sv
// Single-port byte-enabled RAM with a registered read port (read-first).
module snic_sp_ram #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 4096,
   localparam int unsigned STRB_W = DATA_W/8,
   localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              en,
   input  logic [STRB_W-1:0] we,
   input  logic [IDX_W-1:0]  addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         for (int unsigned b = 0; b < STRB_W; b++) begin
            if (we[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
         end
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/axil_dmem_ctrl.sv
// AXI-Lite slave fronting the data memory: one transaction in flight, with
// read/write arbitration that alternates on simultaneous requests.
module axil_dmem_ctrl
   import snic_rv_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned STRB_W    = DATA_W/8,
   parameter int unsigned MEM_DEPTH = 4096
) (
   input  logic        aclk,
   input  logic        areset,
   taxi_axil_if.wr_slv s_wr_if,
   taxi_axil_if.rd_slv s_rd_if
);
   localparam int unsigned LSB_W = $clog2(STRB_W);
   localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

   state_e            state, state_nxt;
   prio_e             prio;
   logic              aw_held, w_held, wr_err, rd_err;
   logic [IDX_W-1:0]  wr_idx, rd_idx;
   logic [DATA_W-1:0] w_data;
   logic [STRB_W-1:0] w_strb;
   logic              no_held, aw_hs, w_hs, ar_hs, wr_go;

   logic              awready_c, wready_c, arready_c, bvalid_c, rvalid_c;
   logic [RESP_W-1:0] bresp_c, rresp_c;
   logic [DATA_W-1:0] rdata_c;

   logic              ram_en;
   logic [STRB_W-1:0] ram_we;
   logic [IDX_W-1:0]  ram_addr;
   logic [DATA_W-1:0] ram_q;
   logic              unused_prot;

   // Any set bit above the word-index field means the access misses the RAM.
   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return (a >> (LSB_W + IDX_W)) == '0;
   endfunction

   assign no_held     = !aw_held && !w_held;
   assign aw_hs       = s_wr_if.awvalid && awready_c;
   assign w_hs        = s_wr_if.wvalid  && wready_c;
   assign ar_hs       = s_rd_if.arvalid && arready_c;
   assign wr_go       = (aw_held || aw_hs) && (w_held || w_hs);
   assign unused_prot = ^{s_wr_if.awprot, s_rd_if.arprot};

   always_ff @(posedge aclk) begin
      if (areset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (wr_go)      state_nxt = WR_EXEC;
            else if (ar_hs) state_nxt = RD_EXEC;
         end
         WR_EXEC: state_nxt = WR_RESP;
         WR_RESP: if (s_wr_if.bready) state_nxt = IDLE;
         RD_EXEC: state_nxt = RD_RESP;
         RD_RESP: if (s_rd_if.rready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Everything is forced quiet while reset is asserted, including the RAM write.
   always_comb begin
      awready_c = 1'b0;
      wready_c  = 1'b0;
      arready_c = 1'b0;
      bvalid_c  = 1'b0;
      bresp_c   = RESP_OKAY;
      rvalid_c  = 1'b0;
      rresp_c   = RESP_OKAY;
      rdata_c   = '0;
      ram_en    = 1'b0;
      ram_we    = '0;
      ram_addr  = wr_idx;
      if (!areset) begin
         unique case (state)
            IDLE: begin
               awready_c = !aw_held && !(no_held && s_rd_if.arvalid && prio == PRIO_READ);
               wready_c  = !w_held  && !(no_held && s_rd_if.arvalid && prio == PRIO_READ);
               arready_c = no_held &&
                           (prio == PRIO_READ || !(s_wr_if.awvalid && s_wr_if.wvalid));
            end
            WR_EXEC: begin
               ram_en   = !wr_err;
               ram_we   = wr_err ? '0 : w_strb;
               ram_addr = wr_idx;
            end
            WR_RESP: begin
               bvalid_c = 1'b1;
               bresp_c  = wr_err ? RESP_SLVERR : RESP_OKAY;
            end
            RD_EXEC: begin
               ram_en   = !rd_err;
               ram_addr = rd_idx;
            end
            RD_RESP: begin
               rvalid_c = 1'b1;
               rresp_c  = rd_err ? RESP_SLVERR : RESP_OKAY;
               rdata_c  = rd_err ? '0 : ram_q;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         prio    <= PRIO_WRITE;
         aw_held <= 1'b0;
         w_held  <= 1'b0;
      end else begin
         if (aw_hs) aw_held <= 1'b1;
         if (w_hs)  w_held  <= 1'b1;
         if (wr_go) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
         end
         if (wr_go || ar_hs) prio <= (prio == PRIO_WRITE) ? PRIO_READ : PRIO_WRITE;
      end
   end

   // Request payload holding registers; contents only matter once a flag is set.
   always_ff @(posedge aclk) begin
      if (aw_hs) begin
         wr_idx <= s_wr_if.awaddr[LSB_W +: IDX_W];
         wr_err <= !in_range(s_wr_if.awaddr);
      end
      if (w_hs) begin
         w_data <= s_wr_if.wdata;
         w_strb <= s_wr_if.wstrb;
      end
      if (ar_hs) begin
         rd_idx <= s_rd_if.araddr[LSB_W +: IDX_W];
         rd_err <= !in_range(s_rd_if.araddr);
      end
   end

   snic_sp_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (MEM_DEPTH)
   ) u_ram (
      .clk   (aclk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (w_data),
      .rdata (ram_q)
   );

   assign s_wr_if.awready = awready_c;
   assign s_wr_if.wready  = wready_c;
   assign s_wr_if.bvalid  = bvalid_c;
   assign s_wr_if.bresp   = bresp_c;
   assign s_rd_if.arready = arready_c;
   assign s_rd_if.rvalid  = rvalid_c;
   assign s_rd_if.rresp   = rresp_c;
   assign s_rd_if.rdata   = rdata_c;

endmodule

// File: tb/tb_axil_dmem_ctrl.sv
// Bench for axil_dmem_ctrl: directed scenarios plus randomized traffic checked
// against an associative-array memory model.
module tb_axil_dmem_ctrl;
   import snic_rv_pkg::*;

   logic aclk = 1'b0;
   logic areset;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   logic [31:0] model [int unsigned];

   taxi_axil_if #(.ADDR_W(32), .DATA_W(32)) axil();

   axil_dmem_ctrl #(
      .ADDR_W(32), .DATA_W(32), .STRB_W(4), .MEM_DEPTH(4096)
   ) dut (
      .aclk    (aclk),
      .areset  (areset),
      .s_wr_if (axil),
      .s_rd_if (axil)
   );

   always #5 aclk = ~aclk;
   always @(posedge aclk) cyc <= cyc + 1;

   // 4096 words of 4 bytes: byte addresses below 0x4000 are in range.
   function automatic bit addr_ok(input logic [31:0] a);
      return a < 32'h4000;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (!addr_ok(a)) return 32'h0;
      if (model.exists(a / 4)) return model[a / 4];
      return 32'h0;
   endfunction

   function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] w;
      if (!addr_ok(a)) return;
      w = model_read(a);
      for (int i = 0; i < 4; i++) if (s[i]) w[i*8 +: 8] = d[i*8 +: 8];
      model[a / 4] = w;
   endfunction

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int lat);
      int hs = -1;
      int t  = 0;
      bit awd = 0, wd = 0;
      lat  = -1;
      resp = 2'b11;
      @(posedge aclk); #1;
      axil.awaddr = a; axil.awprot = 3'($urandom); axil.awvalid = 1'b1;
      axil.wdata = d; axil.wstrb = s; axil.wvalid = 1'b1; axil.bready = 1'b0;
      while (!(awd && wd) && t < 40) begin
         @(negedge aclk);
         if (axil.awvalid && axil.awready) begin awd = 1; hs = cyc; end
         if (axil.wvalid && axil.wready)   begin wd = 1;  hs = cyc; end
         @(posedge aclk); #1;
         if (awd) axil.awvalid = 1'b0;
         if (wd)  axil.wvalid  = 1'b0;
         t++;
      end
      axil.awvalid = 1'b0;
      axil.wvalid  = 1'b0;
      if (!(awd && wd)) begin
         checks++; errors++;
         $display("FAIL write_handshake addr=%h: aw=%0d w=%0d, required both", a, awd, wd);
         return;
      end
      axil.bready = 1'b1;
      t = 0;
      while (t < 40) begin
         @(negedge aclk);
         if (axil.bvalid) begin lat = cyc - hs; resp = axil.bresp; break; end
         t++;
      end
      if (lat < 0) begin
         checks++; errors++;
         $display("FAIL write_bvalid_timeout addr=%h: no bvalid within 40 cycles", a);
      end
      @(posedge aclk); #1;
      axil.bready = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a, input int hold,
                          output logic [31:0] d, output logic [1:0] resp, output int lat);
      int hs = -1;
      int t  = 0;
      logic [31:0] first;
      lat  = -1;
      d    = 32'hx;
      resp = 2'b11;
      @(posedge aclk); #1;
      axil.araddr = a; axil.arprot = 3'($urandom); axil.arvalid = 1'b1; axil.rready = 1'b0;
      while (hs < 0 && t < 40) begin
         @(negedge aclk);
         if (axil.arready) hs = cyc;
         @(posedge aclk); #1;
         if (hs >= 0) axil.arvalid = 1'b0;
         t++;
      end
      axil.arvalid = 1'b0;
      if (hs < 0) begin
         checks++; errors++;
         $display("FAIL read_handshake addr=%h: arready never seen", a);
         return;
      end
      t = 0;
      while (t < 40) begin
         @(negedge aclk);
         if (axil.rvalid) begin lat = cyc - hs; break; end
         t++;
      end
      if (lat < 0) begin
         checks++; errors++;
         $display("FAIL read_rvalid_timeout addr=%h: no rvalid within 40 cycles", a);
         return;
      end
      d = axil.rdata; resp = axil.rresp; first = axil.rdata;
      for (int i = 0; i < hold; i++) begin
         @(posedge aclk); #1;
         @(negedge aclk);
         checks++;
         if (!axil.rvalid || axil.rdata !== first) begin
            errors++;
            $display("FAIL read_stall_stable cycle %0d: rvalid=%b rdata=%h, required 1 / %h",
                     i, axil.rvalid, axil.rdata, first);
         end
      end
      @(posedge aclk); #1;
      axil.rready = 1'b1;
      @(posedge aclk); #1;
      axil.rready = 1'b0;
   endtask

   task automatic pulse_reset();
      @(posedge aclk); #1;
      areset = 1'b1;
      @(posedge aclk); #1;
      areset = 1'b0;
   endtask

   task automatic test_reset();
      @(posedge aclk); #1;
      areset = 1'b1;
      axil.awvalid = 1'b1; axil.wvalid = 1'b1; axil.arvalid = 1'b1;
      @(negedge aclk);
      checks++;
      if ({axil.awready, axil.wready, axil.arready} !== 3'b000) begin
         errors++;
         $display("FAIL reset_readies: got %b, required 000", {axil.awready, axil.wready, axil.arready});
      end
      checks++;
      if ({axil.bvalid, axil.rvalid, axil.bresp, axil.rresp} !== 6'b0 || axil.rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_responses: bvalid=%b rvalid=%b bresp=%b rresp=%b rdata=%h, required all 0",
                  axil.bvalid, axil.rvalid, axil.bresp, axil.rresp, axil.rdata);
      end
      @(posedge aclk); #1;
      areset = 1'b0;
      axil.awvalid = 1'b0; axil.wvalid = 1'b0; axil.arvalid = 1'b0;
      @(negedge aclk);
      checks++;
      if ({axil.awready, axil.wready, axil.arready} !== 3'b111) begin
         errors++;
         $display("FAIL idle_readies: got %b, required 111", {axil.awready, axil.wready, axil.arready});
      end
   endtask

   task automatic test_write_read();
      logic [1:0] resp; int lat; logic [31:0] d;
      do_write(32'h10, 32'hDEADBEEF, 4'hF, resp, lat);
      model_write(32'h10, 32'hDEADBEEF, 4'hF);
      checks++;
      if (resp !== RESP_OKAY || lat != 2) begin
         errors++; $display("FAIL wr_basic: bresp=%b lat=%0d, required 00 / 2", resp, lat);
      end
      do_read(32'h10, 0, d, resp, lat);
      checks++;
      if (d !== 32'hDEADBEEF || resp !== RESP_OKAY || lat != 2) begin
         errors++; $display("FAIL rd_basic: rdata=%h rresp=%b lat=%0d, required deadbeef / 00 / 2", d, resp, lat);
      end
   endtask

   task automatic test_strobes();
      logic [1:0] resp; int lat; logic [31:0] d;
      do_write(32'h20, 32'h11223344, 4'hF, resp, lat);
      model_write(32'h20, 32'h11223344, 4'hF);
      do_write(32'h20, 32'hAABBCCDD, 4'h5, resp, lat);
      model_write(32'h20, 32'hAABBCCDD, 4'h5);
      do_read(32'h20, 0, d, resp, lat);
      checks++;
      if (d !== 32'h11BB33DD || d !== model_read(32'h20)) begin
         errors++; $display("FAIL strobe_merge: rdata=%h, required 11bb33dd", d);
      end
      do_write(32'h20, 32'h55555555, 4'h0, resp, lat);
      checks++;
      if (resp !== RESP_OKAY) begin
         errors++; $display("FAIL zero_strobe_resp: bresp=%b, required 00", resp);
      end
      do_read(32'h20, 0, d, resp, lat);
      checks++;
      if (d !== model_read(32'h20)) begin
         errors++; $display("FAIL zero_strobe_data: rdata=%h, required %h", d, model_read(32'h20));
      end
   endtask

   task automatic test_w_before_aw();
      int hs = -1; int lat = -1; logic [1:0] resp; logic [31:0] d;
      @(posedge aclk); #1;
      axil.wdata = 32'hA5A55A5A; axil.wstrb = 4'hF; axil.wvalid = 1'b1; axil.bready = 1'b1;
      @(negedge aclk);
      checks++;
      if (axil.wready !== 1'b1) begin
         errors++; $display("FAIL w_early_accept: wready=%b, required 1", axil.wready);
      end
      @(posedge aclk); #1;
      axil.wvalid = 1'b0;
      @(negedge aclk);
      checks++;
      if (axil.wready !== 1'b0) begin
         errors++; $display("FAIL w_held_ready: wready=%b, required 0", axil.wready);
      end
      @(posedge aclk); #1;
      @(posedge aclk); #1;
      axil.awaddr = 32'h30; axil.awvalid = 1'b1;
      for (int t = 0; t < 20 && hs < 0; t++) begin
         @(negedge aclk);
         if (axil.awready) hs = cyc;
         @(posedge aclk); #1;
      end
      axil.awvalid = 1'b0;
      model_write(32'h30, 32'hA5A55A5A, 4'hF);
      for (int t = 0; t < 20 && hs >= 0; t++) begin
         @(negedge aclk);
         if (axil.bvalid) begin lat = cyc - hs; resp = axil.bresp; break; end
      end
      @(posedge aclk); #1;
      axil.bready = 1'b0;
      checks++;
      if (lat != 2 || resp !== RESP_OKAY) begin
         errors++; $display("FAIL w_early_bvalid: lat=%0d bresp=%b, required 2 / 00", lat, resp);
      end
      do_read(32'h30, 0, d, resp, lat);
      checks++;
      if (d !== model_read(32'h30)) begin
         errors++; $display("FAIL w_early_data: rdata=%h, required %h", d, model_read(32'h30));
      end
   endtask

   task automatic test_out_of_range();
      logic [1:0] resp; int lat; logic [31:0] d;
      do_write(32'h0, 32'hCAFEF00D, 4'hF, resp, lat);
      model_write(32'h0, 32'hCAFEF00D, 4'hF);
      do_read(32'h0001_0000, 0, d, resp, lat);
      checks++;
      if (resp !== RESP_SLVERR || d !== 32'h0 || lat != 2) begin
         errors++; $display("FAIL oor_read: rresp=%b rdata=%h lat=%0d, required 10 / 0 / 2", resp, d, lat);
      end
      do_write(32'h0001_0000, 32'h12345678, 4'hF, resp, lat);
      checks++;
      if (resp !== RESP_SLVERR) begin
         errors++; $display("FAIL oor_write_resp: bresp=%b, required 10", resp);
      end
      do_read(32'h0, 0, d, resp, lat);
      checks++;
      if (d !== 32'hCAFEF00D || resp !== RESP_OKAY) begin
         errors++; $display("FAIL oor_write_alias: rdata=%h rresp=%b, required cafef00d / 00", d, resp);
      end
   endtask

   task automatic test_stall_and_reset();
      logic [1:0] resp; int lat; logic [31:0] d; bit hs = 0; bit seen = 0;
      do_read(32'h10, 5, d, resp, lat);
      checks++;
      if (d !== model_read(32'h10) || resp !== RESP_OKAY) begin
         errors++; $display("FAIL stall_read: rdata=%h rresp=%b, required %h / 00", d, resp, model_read(32'h10));
      end
      do_write(32'h40, 32'h0BADCAFE, 4'hF, resp, lat);
      model_write(32'h40, 32'h0BADCAFE, 4'hF);
      @(posedge aclk); #1;
      axil.awaddr = 32'h40; axil.awvalid = 1'b1;
      axil.wdata = 32'hFFFFFFFF; axil.wstrb = 4'hF; axil.wvalid = 1'b1; axil.bready = 1'b1;
      @(negedge aclk);
      hs = axil.awready && axil.wready;
      @(posedge aclk); #1;
      axil.awvalid = 1'b0; axil.wvalid = 1'b0;
      areset = 1'b1;
      @(posedge aclk); #1;
      areset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge aclk);
         if (axil.bvalid) seen = 1;
      end
      axil.bready = 1'b0;
      checks++;
      if (!hs || seen) begin
         errors++; $display("FAIL reset_abandon: handshake=%b bvalid_seen=%b, required 1 / 0", hs, seen);
      end
      do_read(32'h40, 0, d, resp, lat);
      checks++;
      if (d !== 32'h0BADCAFE) begin
         errors++; $display("FAIL reset_no_commit: rdata=%h, required 0badcafe", d);
      end
   endtask

   task automatic test_back_to_back();
      byte grants[$];
      logic [31:0] a, d;
      pulse_reset();
      for (int r = 0; r < 2; r++) begin
         bit wg = 0, rg = 0;
         a = 32'h80 + 32'(r * 4);
         d = $urandom;
         @(posedge aclk); #1;
         axil.awaddr = a; axil.wdata = d; axil.wstrb = 4'hF; axil.awvalid = 1'b1; axil.wvalid = 1'b1;
         axil.araddr = a; axil.arvalid = 1'b1; axil.bready = 1'b1; axil.rready = 1'b1;
         for (int c = 0; c < 12; c++) begin
            @(negedge aclk);
            checks++;
            if (axil.bvalid && axil.rvalid) begin
               errors++; $display("FAIL b_r_exclusive: bvalid=1 rvalid=1, required not both");
            end
            if (axil.awvalid && axil.awready && axil.wvalid && axil.wready) begin
               grants.push_back("W"); model_write(a, d, 4'hF); wg = 1;
            end
            if (axil.arvalid && axil.arready) begin
               grants.push_back("R"); rg = 1;
            end
            if (axil.rvalid) begin
               checks++;
               if (axil.rdata !== model_read(a)) begin
                  errors++; $display("FAIL b2b_rdata: got %h, required %h", axil.rdata, model_read(a));
               end
            end
            @(posedge aclk); #1;
            if (wg) begin axil.awvalid = 1'b0; axil.wvalid = 1'b0; end
            if (rg) axil.arvalid = 1'b0;
         end
         axil.awvalid = 1'b0; axil.wvalid = 1'b0; axil.arvalid = 1'b0;
         axil.bready = 1'b0; axil.rready = 1'b0;
      end
      checks++;
      if (grants.size() != 4) begin
         errors++; $display("FAIL grant_count: got %0d, required 4", grants.size());
      end
      for (int i = 0; i < grants.size() && i < 4; i++) begin
         byte exp_g = (i % 2 == 0) ? 8'("W") : 8'("R");
         checks++;
         if (grants[i] !== exp_g) begin
            errors++; $display("FAIL grant_order[%0d]: got %c, required %c", i, grants[i], exp_g);
         end
      end
   endtask

   task automatic test_random();
      logic [1:0] resp; int lat; logic [31:0] a, d, exp_d; logic [3:0] s;
      for (int i = 0; i < 16; i++) begin
         a = 32'h100 + 32'(i * 4);
         d = $urandom;
         do_write(a, d, 4'hF, resp, lat);
         model_write(a, d, 4'hF);
      end
      for (int n = 0; n < 40; n++) begin
         a = 32'h100 + 32'($urandom_range(0, 15) * 4);
         if ($urandom_range(0, 5) == 0) a = a | (($urandom_range(0, 1) == 0) ? 32'h4000 : 32'h0010_0000);
         if ($urandom_range(0, 1) == 0) begin
            d = $urandom;
            s = 4'($urandom);
            do_write(a, d, s, resp, lat);
            model_write(a, d, s);
            checks++;
            if (resp !== (addr_ok(a) ? RESP_OKAY : RESP_SLVERR) || lat != 2) begin
               errors++; $display("FAIL rand_write addr=%h: bresp=%b lat=%0d, required %b / 2",
                                   a, resp, lat, addr_ok(a) ? RESP_OKAY : RESP_SLVERR);
            end
         end else begin
            do_read(a, $urandom_range(0, 3), d, resp, lat);
            exp_d = model_read(a);
            checks++;
            if (d !== exp_d || resp !== (addr_ok(a) ? RESP_OKAY : RESP_SLVERR) || lat != 2) begin
               errors++; $display("FAIL rand_read addr=%h: rdata=%h rresp=%b lat=%0d, required %h / %b / 2",
                                   a, d, resp, lat, exp_d, addr_ok(a) ? RESP_OKAY : RESP_SLVERR);
            end
         end
      end
   endtask

   initial begin
      areset = 1'b1;
      axil.awaddr = '0; axil.awprot = '0; axil.awvalid = 1'b0;
      axil.wdata = '0; axil.wstrb = '0; axil.wvalid = 1'b0; axil.bready = 1'b0;
      axil.araddr = '0; axil.arprot = '0; axil.arvalid = 1'b0; axil.rready = 1'b0;
      test_reset();
      test_write_read();
      test_strobes();
      test_w_before_aw();
      test_out_of_range();
      test_stall_and_reset();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
